// File: rtl/fcvt_wu_s.sv
// Multi-cycle IEEE-754 single-precision to 32-bit unsigned integer converter (RISC-V FCVT.WU.S).
// Five-state sequencer: capture, unpack, round, pack, then a one-cycle result strobe.
module fcvt_wu_s #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_input,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       rm,
  output logic             ready,
  output logic             valid_output,
  output logic [WIDTH-1:0] y,
  output logic [4:0]       fflags
);

  typedef enum logic [2:0] {
    S_GET_INPUT = 3'd0,
    S_UNPACK    = 3'd1,
    S_ROUND     = 3'd2,
    S_PACK      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [4:0] FLAG_NV = 5'b10000;
  localparam logic [4:0] FLAG_NX = 5'b00001;

  state_t r_state;
  state_t w_state_next;

  // captured operand
  logic [WIDTH-1:0] r_a;
  logic [2:0]       r_rm;

  // unpacked fields
  logic              r_sign;
  logic [22:0]       r_frac;
  logic [23:0]       r_m;
  logic signed [8:0] r_e;
  logic              r_is_nan;
  logic              r_is_inf;
  logic              r_is_zero;

  // rounded magnitude
  logic [WIDTH-1:0] r_mag;
  logic             r_g;
  logic             r_s;
  logic             r_ix;
  logic [WIDTH-1:0] r_r;

  // results
  logic [WIDTH-1:0] r_y;
  logic [4:0]       r_fflags;
  logic             r_valid;

  // unpack combinational
  logic signed [8:0] w_e;
  logic              w_exp_max;
  logic              w_exp_zero;

  // round combinational
  logic [4:0]       w_rshamt;
  logic [4:0]       w_lshamt;
  logic [23:0]      w_mask;
  logic [WIDTH-1:0] w_mag;
  logic             w_g;
  logic             w_s;
  logic             w_ix;
  logic             w_inc;
  logic [WIDTH-1:0] w_r;

  // pack combinational
  logic [WIDTH-1:0] w_y;
  logic [4:0]       w_fflags;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_GET_INPUT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_GET_INPUT: if (valid_input) w_state_next = S_UNPACK;
      S_UNPACK:    w_state_next = S_ROUND;
      S_ROUND:     w_state_next = S_PACK;
      S_PACK:      w_state_next = S_DONE;
      S_DONE:      w_state_next = S_GET_INPUT;
      default:     w_state_next = S_GET_INPUT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready = 1'b0;
    if (r_state == S_GET_INPUT) ready = 1'b1;
  end

  assign valid_output = r_valid;
  assign y            = r_y;
  assign fflags       = r_fflags;

  // ---------------- unpack ----------------
  always_comb begin
    w_e        = $signed({1'b0, r_a[30:23]}) - 9'sd127;
    w_exp_max  = (r_a[30:23] == 8'hFF);
    w_exp_zero = (r_a[30:23] == 8'h00);
  end

  // ---------------- round ----------------
  always_comb begin
    w_rshamt = 5'd23 - r_e[4:0];
    w_lshamt = r_e[4:0] - 5'd23;
    w_mask   = (24'd1 << (w_rshamt - 5'd1)) - 24'd1;
    w_mag    = '0;
    w_g      = 1'b0;
    w_s      = 1'b0;
    if (r_is_zero) begin
      w_mag = '0;
    end else if (r_e > 9'sd31) begin
      // out of range (incl. inf/NaN); saturate so a negative operand reads as nonzero
      w_mag = '1;
    end else if (r_e >= 9'sd23) begin
      w_mag = {8'd0, r_m} << w_lshamt;
    end else if (r_e >= 9'sd0) begin
      w_mag = {8'd0, r_m >> w_rshamt};
      w_g   = r_m[w_rshamt - 5'd1];
      w_s   = |(r_m & w_mask);
    end else if (r_e == -9'sd1) begin
      w_g = 1'b1;
      w_s = |r_frac;
    end else begin
      w_s = |r_m;
    end
  end

  always_comb begin
    w_ix  = w_g | w_s;
    w_inc = 1'b0;
    case (r_rm)
      RM_RNE:  w_inc = w_g & (w_s | w_mag[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = w_ix & r_sign;
      RM_RUP:  w_inc = w_ix & ~r_sign;
      RM_RMM:  w_inc = w_g;
      default: w_inc = w_g & (w_s | w_mag[0]);
    endcase
    w_r = w_mag + {{(WIDTH-1){1'b0}}, w_inc};
  end

  // ---------------- pack ----------------
  always_comb begin
    w_y      = '0;
    w_fflags = '0;
    if (r_is_nan) begin
      w_y      = '1;
      w_fflags = FLAG_NV;
    end else if (!r_sign && (r_is_inf || r_e > 9'sd31)) begin
      w_y      = '1;
      w_fflags = FLAG_NV;
    end else if (r_is_inf) begin
      w_fflags = FLAG_NV;
    end else if (r_sign && (r_r != '0)) begin
      w_fflags = FLAG_NV;
    end else if (r_sign) begin
      w_fflags = r_ix ? FLAG_NX : 5'b00000;
    end else begin
      w_y      = r_r;
      w_fflags = r_ix ? FLAG_NX : 5'b00000;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_rm      <= '0;
      r_sign    <= 1'b0;
      r_frac    <= '0;
      r_m       <= '0;
      r_e       <= '0;
      r_is_nan  <= 1'b0;
      r_is_inf  <= 1'b0;
      r_is_zero <= 1'b0;
      r_mag     <= '0;
      r_g       <= 1'b0;
      r_s       <= 1'b0;
      r_ix      <= 1'b0;
      r_r       <= '0;
      r_y       <= '0;
      r_fflags  <= '0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_GET_INPUT: begin
          r_valid <= 1'b0;
          if (valid_input) begin
            r_a  <= a;
            r_rm <= rm;
          end
        end
        S_UNPACK: begin
          r_sign    <= r_a[31];
          r_frac    <= r_a[22:0];
          r_m       <= {~w_exp_zero, r_a[22:0]};
          r_e       <= w_e;
          r_is_nan  <= w_exp_max & (r_a[22:0] != 23'd0);
          r_is_inf  <= w_exp_max & (r_a[22:0] == 23'd0);
          r_is_zero <= w_exp_zero & (r_a[22:0] == 23'd0);
        end
        S_ROUND: begin
          r_mag <= w_mag;
          r_g   <= w_g;
          r_s   <= w_s;
          r_ix  <= w_ix;
          r_r   <= w_r;
        end
        S_PACK: begin
          r_y      <= w_y;
          r_fflags <= w_fflags;
        end
        S_DONE: begin
          r_valid <= 1'b1;
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcvt_wu_s.sv
// Scoreboard bench for fcvt_wu_s: directed test-plan vectors, randomized operands,
// back-to-back issue and mid-operation reset, checked against a real-arithmetic model.
module tb_fcvt_wu_s;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_input = 1'b0;
  logic [31:0] a = '0;
  logic [2:0]  rm = '0;
  logic        ready;
  logic        valid_output;
  logic [31:0] y;
  logic [4:0]  fflags;

  always #5 clk = ~clk;

  fcvt_wu_s #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_input(valid_input), .a(a), .rm(rm),
    .ready(ready), .valid_output(valid_output), .y(y), .fflags(fflags)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  f;
    int          edge_idx;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   last_acc = -1000;
  bit   started  = 1'b0;
  int   pulses   = 0;

  bit          dir_use = 1'b0;
  logic [31:0] dir_y   = '0;
  logic [4:0]  dir_f   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: value as a real, rounded with plain floor/compare arithmetic.
  function automatic exp_t ref_conv(input logic [31:0] v, input logic [2:0] rmode, input int eidx);
    exp_t r;
    int   ex, fr;
    real  mag, fl, frc, rnd;
    bit   up;
    r.edge_idx = eidx;
    ex = int'(v[30:23]);
    fr = int'(v[22:0]);
    if (ex == 255) begin
      r.f = 5'h10;
      r.y = (fr != 0 || !v[31]) ? 32'hFFFFFFFF : 32'h0;
      return r;
    end
    if (ex == 0) mag = real'(fr) * (2.0 ** -149.0);
    else         mag = real'(fr + 8388608) * (2.0 ** real'(ex - 150));
    if (mag >= 4294967296.0) begin
      r.f = 5'h10;
      r.y = v[31] ? 32'h0 : 32'hFFFFFFFF;
      return r;
    end
    fl  = $floor(mag);
    frc = mag - fl;
    case (rmode)
      3'd1:    up = 1'b0;
      3'd2:    up = v[31] && (frc > 0.0);
      3'd3:    up = !v[31] && (frc > 0.0);
      3'd4:    up = (frc >= 0.5);
      default: up = (frc > 0.5) || ((frc == 0.5) && ($floor(fl / 2.0) * 2.0 != fl));
    endcase
    rnd = up ? fl + 1.0 : fl;
    if (v[31] && rnd != 0.0) begin
      r.y = 32'h0;
      r.f = 5'h10;
    end else if (v[31]) begin
      r.y = 32'h0;
      r.f = (frc != 0.0) ? 5'h01 : 5'h00;
    end else begin
      r.y = 32'(longint'(rnd));
      r.f = (frc != 0.0) ? 5'h01 : 5'h00;
    end
    return r;
  endfunction

  function automatic exp_t make_exp(input logic [31:0] v, input logic [2:0] rmode, input int eidx);
    exp_t r;
    if (dir_use) begin
      r.y = dir_y;
      r.f = dir_f;
      r.edge_idx = eidx;
    end else begin
      r = ref_conv(v, rmode, eidx);
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  ex;
    logic [22:0] fr;
    int k;
    k  = $urandom_range(0, 7);
    fr = 23'($urandom);
    if ($urandom_range(0, 3) == 0) fr = fr & (23'h7FFFFF << $urandom_range(0, 22));
    if (k == 0)      ex = 8'($urandom);
    else if (k == 1) begin
      case ($urandom_range(0, 5))
        0: ex = 8'd0;   1: ex = 8'd255; 2: ex = 8'd126;
        3: ex = 8'd127; 4: ex = 8'd158; default: ex = 8'd159;
      endcase
    end else ex = 8'($urandom_range(110, 160));
    return {1'($urandom), ex, fr};
  endfunction

  // Acceptance tracker: push expectation on every accepting edge.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    started  <= 1'b1;
    if (rst) begin
      sb.delete();
      last_acc <= -1000;
    end else if (ready && valid_input) begin
      sb.push_back(make_exp(a, rm, edge_cnt));
      last_acc <= edge_cnt;
    end
  end

  // Monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (started && !rst) begin
      check("ready", 64'(ready), 64'((edge_cnt - last_acc) > 4));
      if (valid_output) begin
        pulses <= pulses + 1;
        if (sb.size() == 0) begin
          check("unexpected_valid", 64'(valid_output), 64'd0);
        end else begin
          check("y", 64'(y), 64'(sb[0].y));
          check("fflags", 64'(fflags), 64'(sb[0].f));
          check("latency", 64'(edge_cnt), 64'(sb[0].edge_idx + 5));
          sb.delete(0);
        end
      end else if (sb.size() > 0 && (sb[0].edge_idx + 5) <= edge_cnt) begin
        check("missing_valid", 64'(valid_output), 64'd1);
        sb.delete(0);
      end
    end
  end

  task automatic send(input logic [31:0] va, input logic [2:0] vr, input bit use_dir,
                      input logic [31:0] ey, input logic [4:0] ef);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 64'(ready), 64'd1);
      return;
    end
    a = va; rm = vr; dir_use = use_dir; dir_y = ey; dir_f = ef;
    valid_input = 1'b1;
    @(negedge clk);
    valid_input = 1'b0;
    dir_use = 1'b0;
    a  = $urandom;
    rm = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  localparam int ND = 19;
  logic [31:0] d_a  [ND] = '{32'h4F7FFFFF, 32'h4F800000, 32'h3F800000, 32'h40200000, 32'h40200000,
                             32'h40200000, 32'h40200000, 32'h40200000, 32'h40600000, 32'hBE99999A,
                             32'hBE99999A, 32'hBF800000, 32'h80000000, 32'h7FC00000, 32'h7F800000,
                             32'hFF800000, 32'h00000001, 32'h00000001, 32'h40200000};
  logic [2:0]  d_rm [ND] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1,
                             3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd5};
  logic [31:0] d_y  [ND] = '{32'hFFFFFF00, 32'hFFFFFFFF, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3, 32'd3,
                             32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd0, 32'd1, 32'd0, 32'd2};
  logic [4:0]  d_f  [ND] = '{5'h00, 5'h10, 5'h00, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01,
                             5'h10, 5'h10, 5'h00, 5'h10, 5'h10, 5'h10, 5'h01, 5'h00, 5'h01};

  initial begin
    int p0;
    d_f[17] = 5'h01;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(valid_output), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_fflags", 64'(fflags), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < ND; i++) begin
      send(d_a[i], d_rm[i], 1'b1, d_y[i], d_f[i]);
      drain();
    end

    for (int i = 0; i < 300; i++) begin
      send(rand_op(), 3'($urandom), 1'b0, 32'd0, 5'd0);
    end
    drain();

    // back-to-back issue with valid_input held high
    p0 = pulses;
    valid_input = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a  = rand_op();
      rm = 3'($urandom);
      @(negedge clk);
    end
    valid_input = 1'b0;
    drain();
    check("b2b_pulses", 64'(pulses - p0), 64'd6);

    // reset in the middle of a conversion
    send(32'h4F7FFFFF, 3'd0, 1'b1, 32'hFFFFFF00, 5'h00);
    drain();
    send(32'h40600000, 3'd0, 1'b0, 32'd0, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 64'(valid_output), 64'd0);
    check("midrst_y", 64'(y), 64'd0);
    check("midrst_fflags", 64'(fflags), 64'd0);
    check("midrst_ready", 64'(ready), 64'd1);
    rst = 1'b0;
    p0 = pulses;
    repeat (10) @(negedge clk);
    check("midrst_no_pulse", 64'(pulses - p0), 64'd0);
    send(32'h40600000, 3'd3, 1'b1, 32'd4, 5'h01);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fcvt_wu_s.md
# fcvt_wu_s

Multi-cycle converter from IEEE-754 single precision to 32-bit unsigned integer, implementing RISC-V FCVT.WU.S including rounding modes and exception flags. It sits in the pipeline float unit beside the unsigned-integer-to-float converter and is the reverse-direction counterpart to it. It uses the same valid-in/valid-out handshake, so the FPU issue logic drives both converters identically.

## Interface
- WIDTH, 32, operand and result width; only 32 is supported.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- valid_input  input  1  operand strobe; sampled only in GET_INPUT.
- a  input  WIDTH  single-precision operand.
- rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE (DYN is resolved upstream).
- ready  output  1  high exactly while the state is GET_INPUT.
- valid_output  output  1  one-cycle result strobe.
- y  output  WIDTH  unsigned integer result.
- fflags  output  5  {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0.

## Operation
- FSM states and transitions:
  - GET_INPUT → UNPACK when valid_input=1. On this transition, capture a and rm.
  - UNPACK → ROUND unconditionally.
  - ROUND → PACK unconditionally.
  - PACK → DONE unconditionally.
  - DONE → GET_INPUT unconditionally.
- GET_INPUT clears valid_output.
- UNPACK:
  - Compute sign, exp, frac, and m = {exp!=0, frac} (24 bits).
  - Compute e = exp − 127 as a signed 9-bit value.
  - Classify the operand as NaN, inf, zero, or finite.
- ROUND computes an integer magnitude `mag` plus guard g and sticky s:
  - e ≥ 23: mag = m << (e−23), exact, g=s=0. Only evaluated when e ≤ 31, so mag fits in 32 bits.
  - 0 ≤ e < 23: mag = m >> (23−e). g = first bit shifted out. s = OR of the remaining shifted-out bits.
  - e = −1: mag=0, g=1, s=(frac!=0).
  - e < −1, including denormals: mag=0, g=0, s=(m!=0).
  - Inexact flag: ix = g|s.
  - Increment inc depends on rm:
    - RNE: g&(s|mag[0])
    - RTZ: 0
    - RDN: ix&sign
    - RUP: ix&~sign
    - RMM: g
  - r = mag + inc. For e < 23, r < 2^24, so no carry beyond 32 bits is possible.
- PACK writes y and fflags in priority order:
  1. NaN: y=32'hFFFFFFFF, NV=1.
  2. +inf, or positive with e > 31: y=32'hFFFFFFFF, NV=1.
  3. −inf: y=0, NV=1.
  4. Negative finite with r≠0: y=0, NV=1.
  5. Negative finite with r=0: y=0, NX=ix. This covers −0.0, which produces no flags.
  6. Positive finite: y=r, NX=ix.
- NV and NX are never both set.
- y and fflags hold their values until the next PACK or reset.
- DONE sets valid_output=1.

## Timing
- Reset (rst=1 at a clock edge):
  - state=GET_INPUT, valid_output=0, y=0, fflags=0, ready=1.
  - All internal registers are cleared.
  - Reset has priority over every state. Asserting rst mid-conversion aborts the operation with no valid_output pulse.
- Edge sequence for one operation, with E0 the edge where valid_input is accepted:
  - E0: capture a and rm.
  - E1: UNPACK.
  - E2: ROUND.
  - E3: PACK; y and fflags update.
  - E4: DONE; valid_output rises.
  - E5: valid_output falls.
- Latency is 4 cycles from acceptance to valid_output.
- valid_output stays high for exactly one cycle.
- When valid_output is high, y and fflags are already stable, having been written one cycle earlier.
- ready is low from after E0 through E4.
- valid_input while not in GET_INPUT is ignored and not queued.
- A new operand can be accepted at E5, the same edge on which valid_output clears.
- Peak throughput is one conversion per 5 cycles.
- a and rm only need to be valid at the accepting edge. Changes afterwards do not affect the conversion in flight.

## Test plan
- Range limits, rm=RNE:
  - 0x4F7FFFFF → y=0xFFFFFF00, fflags=0.
  - 0x4F800000 (2^32) → y=0xFFFFFFFF, NV.
  - 0x3F800000 → y=1, fflags=0.
- Rounding modes on 2.5 (0x40200000), all with NX:
  - RNE → 2
  - RTZ → 2
  - RDN → 2
  - RUP → 3
  - RMM → 3
- Rounding on 3.5 (0x40600000), rm=RNE → 4, NX.
- Negative inputs:
  - −0.3 (0xBE99999A), RTZ → 0, NX only.
  - −0.3, RDN → 0, NV only.
  - −1.0 (0xBF800000) → 0, NV.
  - −0.0 (0x80000000) → 0, fflags=0.
- Specials and denormals:
  - 0x7FC00000 → 0xFFFFFFFF, NV.
  - 0x7F800000 → 0xFFFFFFFF, NV.
  - 0xFF800000 → 0, NV.
  - 0x00000001, RUP → 1, NX.
  - 0x00000001, RNE → 0, NX.
- Handshake:
  - Hold valid_input=1 continuously with changing a. Required: exactly one valid_output pulse per 5 cycles, 4 cycles after each acceptance. Each result matches the operand present at its accepting edge. ready is low during busy cycles.
- Reset mid-operation:
  - Assert rst at E2. Required: at the next edge valid_output=0, y=0, fflags=0, ready=1, and no later result pulse.
  - A following conversion then completes normally.
